// File: rtl/aes128_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// aes128_inv_key_schedule
//
// Iterative AES-128 inverse key schedule. A round-10 key is accepted in IDLE
// and the round keys are streamed out in descending order (round 10 .. 0),
// one beat per EMIT/CALC pair, over a valid/ready handshake. A single
// SubWord path built from four registered sbox_8bits instances is shared by
// every round step.
//
// Ports:
//   clk           in   1    single clock
//   rst_n         in   1    asynchronous active-low reset
//   key_in        in   128  round-10 key, word 0 in [127:96]
//   key_in_valid  in   1    key_in valid
//   key_in_ready  out  1    idle, a key can be accepted
//   rk_out        out  128  current round key
//   rk_round      out  4    round index of rk_out (10..0)
//   rk_valid      out  1    rk_out valid
//   rk_ready      in   1    consumer accepts rk_out
//   rk_last       out  1    high with the round-0 beat
//   busy          out  1    high from key accept until the round-0 beat
//   abort         in   1    (only with AES_INVKEY_ABORT_EN) drop the stream
//
// Build option: define AES_INVKEY_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------

// Registered AES forward S-box on one byte (GF(2^8) inverse + affine map).
module sbox_8bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    logic [7:0] sbox_d;
    logic [7:0] sbox_q;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end else begin
                p = p;
            end
            t = gf_xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0); it is built as
    // the product x^2 * x^4 * ... * x^128.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Combinational substitution of the incoming byte.
    always_comb begin
        sbox_d = sbox_byte(sbox_in);
    end

    // Output register of the S-box.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbox_q <= 8'h00;
        end else begin
            sbox_q <= sbox_d;
        end
    end

    assign sbox_out = sbox_q;

endmodule

module aes128_inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_in_valid,
    output logic         key_in_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy
`ifdef AES_INVKEY_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_CALC = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [127:0] cur_q;
    logic [127:0] cur_d;
    logic [3:0]   rnd_q;
    logic [3:0]   rnd_d;
    logic         key_in_ready_q;
    logic         key_in_ready_d;
    logic         rk_valid_q;
    logic         rk_valid_d;
    logic         rk_last_q;
    logic         rk_last_d;
    logic         busy_q;
    logic         busy_d;
    logic         abort_s;

    logic [31:0]  prev_w0_s;
    logic [31:0]  prev_w1_s;
    logic [31:0]  prev_w2_s;
    logic [31:0]  prev_w3_s;
    logic [31:0]  rot_w3_s;
    logic [31:0]  sub_w3_s;
    logic [127:0] prev_key_s;

`ifdef AES_INVKEY_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // cur = {w4, w5, w6, w7}; the previous key's w3 feeds the S-box in every
    // state so the registered SubWord result is ready when CALC arrives.
    assign prev_w3_s = cur_q[31:0] ^ cur_q[63:32];
    assign rot_w3_s  = {prev_w3_s[23:0], prev_w3_s[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            sbox_8bits u_sbox (
                .clk      (clk),
                .rst_n    (rst_n),
                .sbox_in  (rot_w3_s[8*gi +: 8]),
                .sbox_out (sub_w3_s[8*gi +: 8])
            );
        end
    endgenerate

    assign prev_w2_s  = cur_q[63:32] ^ cur_q[95:64];
    assign prev_w1_s  = cur_q[95:64] ^ cur_q[127:96];
    assign prev_w0_s  = cur_q[127:96] ^ sub_w3_s ^ {rcon_byte(rnd_q), 24'h000000};
    assign prev_key_s = {prev_w0_s, prev_w1_s, prev_w2_s, prev_w3_s};

    // Next-state, key register and registered-output decode.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rnd_d   = rnd_q;
        case (state_q)
            ST_IDLE: begin
                if (key_in_valid) begin
                    cur_d   = key_in;
                    rnd_d   = 4'd10;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                // Abort takes priority: a simultaneous handshake is dropped.
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else if (rk_ready) begin
                    if (rnd_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_CALC: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_d   = prev_key_s;
                    rnd_d   = rnd_q - 4'd1;
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        key_in_ready_d = (state_d == ST_IDLE);
        rk_valid_d     = (state_d == ST_EMIT);
        rk_last_d      = (state_d == ST_EMIT) && (rnd_d == 4'd0);
        busy_d         = (state_d != ST_IDLE);
    end

    // State, key and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cur_q          <= 128'h0;
            rnd_q          <= 4'd0;
            key_in_ready_q <= 1'b1;
            rk_valid_q     <= 1'b0;
            rk_last_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            rnd_q          <= rnd_d;
            key_in_ready_q <= key_in_ready_d;
            rk_valid_q     <= rk_valid_d;
            rk_last_q      <= rk_last_d;
            busy_q         <= busy_d;
        end
    end

    assign key_in_ready = key_in_ready_q;
    assign rk_out       = cur_q;
    assign rk_round     = rnd_q;
    assign rk_valid     = rk_valid_q;
    assign rk_last      = rk_last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_aes128_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// Testbench for aes128_inv_key_schedule. Reference round keys come from the
// textbook w[i] recurrence solved backwards with a table S-box.
// ---------------------------------------------------------------------------
module tb_aes128_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_in_valid;
    logic         key_in_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;
`ifdef AES_INVKEY_ABORT_EN
    logic         abort;
`endif

    int errors = 0;
    int checks = 0;

    logic [127:0] sbox_rows [16];
    logic [7:0]   rcon_tab  [11];
    logic [127:0] exp_rk    [11];
    logic [127:0] got_rk    [11];

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    aes128_inv_key_schedule dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_in_valid (key_in_valid),
        .key_in_ready (key_in_ready),
        .rk_out       (rk_out),
        .rk_round     (rk_round),
        .rk_valid     (rk_valid),
        .rk_ready     (rk_ready),
        .rk_last      (rk_last),
        .busy         (busy)
`ifdef AES_INVKEY_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        int           idx;
        row = sbox_rows[x[7:4]];
        idx = 15 - int'(x[3:0]);
        return row[idx*8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    task automatic build_model(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        w[40] = k10[127:96];
        w[41] = k10[95:64];
        w[42] = k10[63:32];
        w[43] = k10[31:0];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/4], 24'h000000};
            end
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic run_stream(input logic [127:0] key, input bit bp, input bit toggle,
                              output int nbeats);
        int           cyc;
        int           exp_round;
        bit           prev_stall;
        logic [127:0] prev_out;
        logic [3:0]   prev_round;
        logic         rdy;
        build_model(key);
        cyc = 0;
        while (!key_in_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check("ready_before_key", 128'(key_in_ready), 128'(1'b1));
        key_in       = key;
        key_in_valid = 1'b1;
        rk_ready     = 1'b1;
        tick();
        key_in_valid = 1'b0;
        cyc          = 1;
        exp_round    = 10;
        prev_stall   = 1'b0;
        prev_out     = '0;
        prev_round   = '0;
        nbeats       = 0;
        while (exp_round >= 0 && cyc < 400) begin
            if (toggle) begin
                key_in_valid = 1'($urandom_range(0, 1));
                key_in       = {$urandom, $urandom, $urandom, $urandom};
            end
            if (prev_stall) begin
                check("stall_rk_out", rk_out, prev_out);
                check("stall_rk_round", 128'(rk_round), 128'(prev_round));
                check("stall_rk_valid", 128'(rk_valid), 128'(1'b1));
            end
            rdy      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = rdy;
            if (rk_valid && rdy) begin
                check("beat_rk_out", rk_out, exp_rk[exp_round]);
                check("beat_rk_round", 128'(rk_round), 128'(exp_round));
                check("beat_rk_last", 128'(rk_last), 128'(exp_round == 0));
                check("beat_busy", 128'(busy), 128'(1'b1));
                if (!bp) begin
                    check("beat_cycle", 128'(cyc), 128'(21 - 2*exp_round));
                end
                got_rk[exp_round] = rk_out;
                nbeats++;
                exp_round--;
            end
            prev_stall = rk_valid && !rdy;
            prev_out   = rk_out;
            prev_round = rk_round;
            tick();
            cyc++;
        end
        key_in_valid = 1'b0;
        rk_ready     = 1'b0;
        check("stream_beats", 128'(nbeats), 128'(11));
        check("after_ready", 128'(key_in_ready), 128'(1'b1));
        check("after_busy", 128'(busy), 128'(1'b0));
        check("after_valid", 128'(rk_valid), 128'(1'b0));
        if (!bp) begin
            check("after_cycle", 128'(cyc), 128'(22));
        end
    endtask

    initial begin
        int           nb;
        int           cyc;
        logic [7:0]   rc;
        logic [127:0] rkey;

        sbox_rows = '{
            128'h637c777bf26b6fc53001672bfed7ab76,
            128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115,
            128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84,
            128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8,
            128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973,
            128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479,
            128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
            128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df,
            128'h8ca1890dbfe6426841992d0fb054bb16
        };
        rc = 8'h01;
        rcon_tab[0] = 8'h00;
        for (int j = 1; j <= 10; j++) begin
            rcon_tab[j] = rc;
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end

        rst_n        = 1'b0;
        key_in       = '0;
        key_in_valid = 1'b0;
        rk_ready     = 1'b0;
`ifdef AES_INVKEY_ABORT_EN
        abort        = 1'b0;
`endif
        repeat (3) tick();
        check("rst_rk_valid", 128'(rk_valid), 128'(1'b0));
        check("rst_rk_out", rk_out, 128'h0);
        check("rst_rk_round", 128'(rk_round), 128'(4'd0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_rk_last", 128'(rk_last), 128'(1'b0));
        rst_n = 1'b1;
        tick();
        check("rst_key_in_ready", 128'(key_in_ready), 128'(1'b1));

        // FIPS-197 vector, no backpressure.
        run_stream(FIPS_K10, 1'b0, 1'b0, nb);
        check("fips_r10", got_rk[10], FIPS_K10);
        check("fips_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        check("fips_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Zero cipher key presented at cycle 22, key_in_valid toggled while streaming.
        run_stream(ZERO_K10, 1'b0, 1'b1, nb);
        check("zero_r0", got_rk[0], 128'h0);

        // FIPS vector under random backpressure.
        run_stream(FIPS_K10, 1'b1, 1'b0, nb);
        check("fips_bp_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Random keys, with and without backpressure.
        for (int k = 0; k < 4; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_stream(rkey, 1'(k % 2), 1'b0, nb);
        end

        // Asynchronous reset in the middle of the round-5 beat.
        key_in       = {$urandom, $urandom, $urandom, $urandom};
        key_in_valid = 1'b1;
        rk_ready     = 1'b1;
        tick();
        key_in_valid = 1'b0;
        cyc = 0;
        while (!(rk_valid && rk_round == 4'd5) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("mid_reached_r5", 128'(rk_round), 128'(4'd5));
        rst_n = 1'b0;
        #1;
        check("mid_rst_rk_out", rk_out, 128'h0);
        check("mid_rst_rk_round", 128'(rk_round), 128'(4'd0));
        check("mid_rst_rk_valid", 128'(rk_valid), 128'(1'b0));
        check("mid_rst_busy", 128'(busy), 128'(1'b0));
        check("mid_rst_rk_last", 128'(rk_last), 128'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_ready", 128'(key_in_ready), 128'(1'b1));
        rkey = {$urandom, $urandom, $urandom, $urandom};
        run_stream(rkey, 1'b0, 1'b0, nb);

`ifdef AES_INVKEY_ABORT_EN
        // Abort during the round-6 beat while rk_ready is high.
        key_in       = FIPS_K10;
        key_in_valid = 1'b1;
        rk_ready     = 1'b1;
        tick();
        key_in_valid = 1'b0;
        cyc = 0;
        while (!(rk_valid && rk_round == 4'd6) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("abort_reached_r6", 128'(rk_round), 128'(4'd6));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_ready", 128'(key_in_ready), 128'(1'b1));
        for (int c = 0; c < 4; c++) begin
            check("abort_no_valid", 128'(rk_valid), 128'(1'b0));
            check("abort_no_busy", 128'(busy), 128'(1'b0));
            check("abort_no_last", 128'(rk_last), 128'(1'b0));
            tick();
        end
        rk_ready = 1'b0;
`else
        // Same FIPS run without an abort port completes all 11 beats.
        run_stream(FIPS_K10, 1'b0, 1'b0, nb);
        check("noabort_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_inv_key_schedule.md
# aes128_inv_key_schedule

Iterative AES-128 inverse key schedule. Accepts the round-10 key and streams the round keys in descending order, round 10 down to round 0, over a valid/ready interface. It feeds the decryption round datapath, which consumes round keys in reverse order to the forward `key_expansion*` pipeline. One shared `function_t`-style SubWord path (four registered `sbox_8bits` instances) is reused across all rounds.

## Interface
Parameters:
- none; AES-128 only, Rcon table fixed.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `key_in`  in  128  round-10 key, word 0 in [127:96].
- `key_in_valid`  in  1  `key_in` valid.
- `key_in_ready`  out  1  block idle; can accept a key.
- `rk_out`  out  128  current round key.
- `rk_round`  out  4  round index of `rk_out`, 10..0.
- `rk_valid`  out  1  `rk_out` valid.
- `rk_ready`  in  1  consumer accepts `rk_out`.
- `rk_last`  out  1  high with the round-0 beat.
- `busy`  out  1  high from key accept until the round-0 beat completes.

## Operation
- Key register `cur` [127:0] holds words w4..w7 of round key `rnd` (4-bit counter).
- States: IDLE, EMIT, CALC.
- IDLE:
  - `key_in_ready`=1.
  - On `key_in_valid`: `cur`←`key_in`, `rnd`←10, go to EMIT.
- EMIT:
  - `rk_valid`=1, `rk_out`=`cur`, `rk_round`=`rnd`, `rk_last`=(`rnd`==0).
  - On `rk_ready`: if `rnd`==0, go to IDLE; else go to CALC.
  - Without `rk_ready`, stay in EMIT with all outputs stable.
- CALC:
  - `cur` ← previous key; `rnd`←`rnd`−1; go to EMIT.
- Previous-key arithmetic, all XOR on 32-bit words, from current w4..w7:
  - w3 = w7^w6, w2 = w6^w5, w1 = w5^w4.
  - w0 = w4 ^ (SubWord(RotWord(w3)) ^ Rcon(`rnd`)).
  - RotWord(a,b,c,d) = (b,c,d,a).
  - Rcon(`rnd`) in byte 3: 1:01, 2:02, 3:04, 4:08, 5:10, 6:20, 7:40, 8:80, 9:1B, 10:36.
- S-box inputs are driven combinationally from w3 of `cur` in every state. Because `cur` is stable during EMIT, the registered S-box output is valid in CALC.
- `key_in_valid` outside IDLE is ignored; `key_in_ready`=0.
- Reset, including mid-operation: state→IDLE; `cur`, `rnd`, `rk_out`, `rk_round`=0; `rk_valid`, `rk_last`, `busy`=0; `key_in_ready`=1 once `rst_n` is high. Any partial stream is discarded.

## Timing
- Accept edge = cycle 0. With `rk_ready` held high:
  - round 10 beat in cycle 1, round 9 in cycle 3, round k in cycle 21−2k;
  - round 0 beat (`rk_last`) in cycle 21;
  - `key_in_ready` high in cycle 22.
- Throughput: one round key per 2 cycles, 22 cycles per key minimum. There is no back-to-back overlap across keys.
- `rk_ready` stall of N cycles in EMIT delays all later beats by N. Recomputed keys are unaffected, because the S-box re-registers the same w3.
- `rk_ready` low in CALC has no effect.
- `busy`=1 from cycle 1 through the round-0 beat.

## Configuration
- `AES_INVKEY_ABORT_EN` defined:
  - adds input port `abort` (1 bit);
  - `abort`=1 in EMIT or CALC → IDLE on the next edge, with `rk_valid`=0, `busy`=0, and no `rk_last`;
  - `abort` in IDLE is ignored;
  - `abort` wins over a simultaneous `rk_ready` handshake, and that beat counts as not transferred.
- Undefined: no `abort` port; every accepted key produces exactly 11 beats.

## Test plan
- FIPS-197 vector, key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, `rk_ready`=1 → beats:
  - round 10 equals input;
  - round 9 = ac7766f319fadc2128d12941575c006e;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c with `rk_last`=1 in cycle 21.
- Zero cipher key, key_in = b4ef5bcb3e92e21123e951cf6f8f188e → round 0 = 0, 11 beats, `rk_round` 10..0 strictly descending.
- Random `rk_ready` backpressure on the FIPS vector:
  - identical 11 keys;
  - `rk_out`/`rk_round` never change while `rk_valid`&&!`rk_ready`.
- `rst_n` pulsed low at round 5 beat → outputs 0 asynchronously, `key_in_ready`=1 after release; a new key then yields a full correct stream.
- `key_in_valid` toggled during streaming → ignored; stream unchanged. A second key presented in cycle 22 is accepted.
- With `AES_INVKEY_ABORT_EN`: `abort` during the round 6 beat with `rk_ready`=1 → no further beats, IDLE next cycle. Without the macro, the same run completes all 11 beats.
